// File: rtl/sbqm_pkg.sv
// Shared types and constants for the queue counter and its wait-time calculator.
package sbqm_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } state_t;

    localparam int MAX_COUNT_DEF = 7;
    localparam int SVC_TIME_DEF  = 3;

    localparam int PCOUNT_W = 3;
    localparam int TCOUNT_W = 2;
    localparam int WTIME_W  = 5;

endpackage

// File: rtl/wait_time_calc.sv
// Combinational wait estimate: floor(SVC_TIME*(pcount+T-1)/T), with T = max(tcount,1).
module wait_time_calc
    import sbqm_pkg::*;
#(
    parameter int SVC_TIME = SVC_TIME_DEF
) (
    input  logic [PCOUNT_W-1:0] pcount,
    input  logic [TCOUNT_W-1:0] tcount,
    output logic [WTIME_W-1:0]  wtime
);

    logic [TCOUNT_W-1:0] tellers;
    logic [15:0]         numer;
    logic [15:0]         quot;

    always_comb begin
        tellers = (tcount == '0) ? TCOUNT_W'(1) : tcount;
        numer   = 16'(SVC_TIME) * (16'(pcount) + 16'(tellers) - 16'd1);
        quot    = numer / 16'(tellers);
        wtime   = (pcount == '0) ? '0 : WTIME_W'(quot);
    end

endmodule

// File: rtl/queue_counter.sv
// Queue occupancy FSM with registered flags and a registered wait-time estimate.
// Optional sticky err output (ignored entry/exit) is enabled by defining QUEUE_ERR_EN.
//
//   state   | meaning
//   EMPTY   | no customers queued, empty=1
//   PARTIAL | 1..MAX_COUNT-1 customers queued
//   FULL    | MAX_COUNT customers queued, full=1
module queue_counter
    import sbqm_pkg::*;
#(
    parameter int MAX_COUNT = MAX_COUNT_DEF,
    parameter int SVC_TIME  = SVC_TIME_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                entry_pls,
    input  logic                exit_pls,
    input  logic [TCOUNT_W-1:0] tcount,
    output logic [PCOUNT_W-1:0] pcount,
    output logic                full,
    output logic                empty,
    output logic [WTIME_W-1:0]  wtime
`ifdef QUEUE_ERR_EN
    ,
    output logic                err
`endif
);

    localparam logic [PCOUNT_W-1:0] MAX_P = PCOUNT_W'(MAX_COUNT);

    state_t              state;
    logic                inc_only;
    logic                dec_only;
    logic [PCOUNT_W-1:0] pcount_inc;
    logic [PCOUNT_W-1:0] pcount_dec;
    logic [WTIME_W-1:0]  wtime_calc;

    // Simultaneous entry and exit cancel, so only exclusive pulses move the count.
    always_comb begin
        inc_only   = entry_pls & ~exit_pls;
        dec_only   = exit_pls & ~entry_pls;
        pcount_inc = pcount + PCOUNT_W'(1);
        pcount_dec = pcount - PCOUNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= EMPTY;
            pcount <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (inc_only) begin
                        pcount <= pcount_inc;
                        empty  <= 1'b0;
                        if (pcount_inc == MAX_P) begin
                            state <= FULL;
                            full  <= 1'b1;
                        end else begin
                            state <= PARTIAL;
                        end
                    end
                end
                PARTIAL: begin
                    if (inc_only) begin
                        pcount <= pcount_inc;
                        if (pcount_inc == MAX_P) begin
                            state <= FULL;
                            full  <= 1'b1;
                        end
                    end else if (dec_only) begin
                        pcount <= pcount_dec;
                        if (pcount_dec == '0) begin
                            state <= EMPTY;
                            empty <= 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (dec_only) begin
                        pcount <= pcount_dec;
                        full   <= 1'b0;
                        if (pcount_dec == '0) begin
                            state <= EMPTY;
                            empty <= 1'b1;
                        end else begin
                            state <= PARTIAL;
                        end
                    end
                end
                default: begin
                    state  <= EMPTY;
                    pcount <= '0;
                    full   <= 1'b0;
                    empty  <= 1'b1;
                end
            endcase
        end
    end

    wait_time_calc #(
        .SVC_TIME (SVC_TIME)
    ) u_wait_time_calc (
        .pcount (pcount),
        .tcount (tcount),
        .wtime  (wtime_calc)
    );

    // Registered from the already-registered pcount: one cycle behind the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wtime <= '0;
        end else begin
            wtime <= wtime_calc;
        end
    end

`ifdef QUEUE_ERR_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if ((inc_only && state == FULL) || (dec_only && state == EMPTY)) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_queue_counter.sv
// Self-checking bench for queue_counter: scoreboard of expected outputs per driven cycle
// plus directed scenario checks. Define QUEUE_ERR_EN to also check the err output.
module tb_queue_counter;

    localparam int MAXC = 7;
    localparam int SVC  = 3;

    logic       clk;
    logic       rst;
    logic       entry_pls;
    logic       exit_pls;
    logic [1:0] tcount;
    logic [2:0] pcount;
    logic       full;
    logic       empty;
    logic [4:0] wtime;
`ifdef QUEUE_ERR_EN
    logic       err;
`else
    logic       err;
    assign err = 1'b0;
`endif

    typedef struct {
        logic [2:0] p;
        logic       f;
        logic       e;
        logic [4:0] w;
        logic       er;
    } exp_t;

    exp_t sb[$];
    int   m_cnt;
    logic m_err;
    int   n_checks;
    int   n_fail;

    queue_counter dut (
        .clk       (clk),
        .rst       (rst),
        .entry_pls (entry_pls),
        .exit_pls  (exit_pls),
        .tcount    (tcount),
        .pcount    (pcount),
        .full      (full),
        .empty     (empty),
        .wtime     (wtime)
`ifdef QUEUE_ERR_EN
        ,
        .err       (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    function automatic int wt_model(input int p, input int t);
        int te;
        te = (t == 0) ? 1 : t;
        if (p == 0) return 0;
        return (SVC * (p + te - 1)) / te;
    endfunction

    // One clock of stimulus: model the expected result, drive, then compare after the edge.
    task automatic step(input logic en, input logic ex);
        exp_t x;
        @(negedge clk);
        entry_pls = en;
        exit_pls  = ex;
        x.w = 5'(wt_model(m_cnt, int'(tcount)));
        if (en && !ex) begin
            if (m_cnt < MAXC) m_cnt++;
            else m_err = 1'b1;
        end else if (ex && !en) begin
            if (m_cnt > 0) m_cnt--;
            else m_err = 1'b1;
        end
        x.p  = 3'(m_cnt);
        x.f  = (m_cnt == MAXC);
        x.e  = (m_cnt == 0);
        x.er = m_err;
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        n_checks++;
        if (pcount !== x.p) begin
            n_fail++;
            $display("FAIL sb_pcount: actual=%0d required=%0d", pcount, x.p);
        end
        n_checks++;
        if (full !== x.f) begin
            n_fail++;
            $display("FAIL sb_full: actual=%b required=%b", full, x.f);
        end
        n_checks++;
        if (empty !== x.e) begin
            n_fail++;
            $display("FAIL sb_empty: actual=%b required=%b", empty, x.e);
        end
        n_checks++;
        if (wtime !== x.w) begin
            n_fail++;
            $display("FAIL sb_wtime: actual=%0d required=%0d", wtime, x.w);
        end
`ifdef QUEUE_ERR_EN
        n_checks++;
        if (err !== x.er) begin
            n_fail++;
            $display("FAIL sb_err: actual=%b required=%b", err, x.er);
        end
`endif
        entry_pls = 1'b0;
        exit_pls  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        m_cnt = 0;
        m_err = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        n_checks++;
        if (pcount !== 3'd0 || empty !== 1'b1 || full !== 1'b0 || wtime !== 5'd0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: actual p=%0d e=%b f=%b w=%0d err=%b required p=0 e=1 f=0 w=0 err=0",
                     pcount, empty, full, wtime, err);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_entry_sequence();
        tcount = 2'd1;
        for (int i = 1; i <= 3; i++) begin
            step(1'b1, 1'b0);
            n_checks++;
            if (pcount !== 3'(i)) begin
                n_fail++;
                $display("FAIL entry_seq_pcount: actual=%0d required=%0d", pcount, i);
            end
        end
        step(1'b0, 1'b0);
        n_checks++;
        if (wtime !== 5'd9) begin
            n_fail++;
            $display("FAIL entry_seq_wtime: actual=%0d required=9", wtime);
        end
    endtask

    task automatic test_tcount();
        logic [1:0] tv[4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        logic [4:0] wv[4] = '{5'd15, 5'd9, 5'd7, 5'd15};
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tcount = tv[i];
            step(1'b0, 1'b0);
            n_checks++;
            if (wtime !== wv[i]) begin
                n_fail++;
                $display("FAIL tcount_wtime t=%0d: actual=%0d required=%0d", tv[i], wtime, wv[i]);
            end
        end
        tcount = 2'd1;
    endtask

    task automatic test_full();
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        n_checks++;
        if (full !== 1'b1 || pcount !== 3'd7 || wtime !== 5'd21) begin
            n_fail++;
            $display("FAIL full_state: actual p=%0d f=%b w=%0d required p=7 f=1 w=21", pcount, full, wtime);
        end
        step(1'b1, 1'b0);
        n_checks++;
        if (pcount !== 3'd7) begin
            n_fail++;
            $display("FAIL full_ignore: actual=%0d required=7", pcount);
        end
`ifdef QUEUE_ERR_EN
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL full_err: actual=%b required=1", err);
        end
`endif
        // Both together while FULL must hold the count.
        step(1'b1, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1);
        n_checks++;
        if (empty !== 1'b1 || pcount !== 3'd0) begin
            n_fail++;
            $display("FAIL drain_empty: actual p=%0d e=%b required p=0 e=1", pcount, empty);
        end
    endtask

    task automatic test_boundary();
        do_reset();
        step(1'b0, 1'b1);
        n_checks++;
        if (pcount !== 3'd0 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL empty_exit: actual p=%0d e=%b required p=0 e=1", pcount, empty);
        end
        step(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        n_checks++;
        if (pcount !== 3'd4) begin
            n_fail++;
            $display("FAIL both_pulses: actual=%0d required=4", pcount);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (pcount !== 3'd0 || empty !== 1'b1 || full !== 1'b0 || wtime !== 5'd0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: actual p=%0d e=%b f=%b w=%0d err=%b required p=0 e=1 f=0 w=0 err=0",
                     pcount, empty, full, wtime, err);
        end
        m_cnt = 0;
        m_err = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 1'b0);
        n_checks++;
        if (pcount !== 3'd1) begin
            n_fail++;
            $display("FAIL post_reset_count: actual=%0d required=1", pcount);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            tcount = 2'($urandom_range(0, 3));
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        m_cnt     = 0;
        m_err     = 1'b0;
        rst       = 1'b0;
        entry_pls = 1'b0;
        exit_pls  = 1'b0;
        tcount    = 2'd1;
        test_reset();
        test_entry_sequence();
        test_tcount();
        test_full();
        test_boundary();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
